// File: rtl/di_axil_pkg.sv
// Shared constants and byte-strobe helpers for the AXI-Lite register slave.
package di_axil_pkg;

    localparam logic [2:0] WORD_STATUS  = 3'd4;
    localparam logic [2:0] WORD_VERSION = 3'd5;
    localparam logic [2:0] WORD_EVENT   = 3'd6;
    localparam logic [2:0] WORD_MASK    = 3'd7;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [31:0] DEFAULT_VERSION = 32'h0001_0000;

    function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
        logic [31:0] m;
        m = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            m[i*8 +: 8] = {8{strb[i]}};
        end
        return m;
    endfunction

    function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] m;
        m = strb_to_mask(strb);
        return (old_val & ~m) | (new_val & m);
    endfunction

endpackage

// File: rtl/di_axil_wr_capture.sv
// Independent AW/W capture; pairs the two and raises a one-cycle commit.
module di_axil_wr_capture #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic                  busy_i,
    input  logic                  awvalid_i,
    input  logic [ADDR_W-1:0]     awaddr_i,
    output logic                  awready_o,
    input  logic                  wvalid_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic [DATA_W/8-1:0]   wstrb_i,
    output logic                  wready_o,
    output logic                  commit_o,
    output logic [ADDR_W-1:0]     addr_o,
    output logic [DATA_W-1:0]     data_o,
    output logic [DATA_W/8-1:0]   strb_o
);

    logic                aw_pend_q, aw_pend_d;
    logic                w_pend_q,  w_pend_d;
    logic [ADDR_W-1:0]   addr_q,    addr_d;
    logic [DATA_W-1:0]   data_q,    data_d;
    logic [DATA_W/8-1:0] strb_q,    strb_d;
    logic                aw_hs, w_hs;

    assign awready_o = en_i & ~aw_pend_q & ~busy_i;
    assign wready_o  = en_i & ~w_pend_q  & ~busy_i;
    assign aw_hs     = awvalid_i & awready_o;
    assign w_hs      = wvalid_i  & wready_o;
    assign commit_o  = aw_pend_q & w_pend_q;
    assign addr_o    = addr_q;
    assign data_o    = data_q;
    assign strb_o    = strb_q;

    always_comb begin
        aw_pend_d = aw_pend_q;
        w_pend_d  = w_pend_q;
        addr_d    = addr_q;
        data_d    = data_q;
        strb_d    = strb_q;
        if (commit_o) begin
            aw_pend_d = 1'b0;
            w_pend_d  = 1'b0;
        end
        if (aw_hs) begin
            aw_pend_d = 1'b1;
            addr_d    = awaddr_i;
        end
        if (w_hs) begin
            w_pend_d = 1'b1;
            data_d   = wdata_i;
            strb_d   = wstrb_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            aw_pend_q <= 1'b0;
            w_pend_q  <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            strb_q    <= '0;
        end else begin
            aw_pend_q <= aw_pend_d;
            w_pend_q  <= w_pend_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            strb_q    <= strb_d;
        end
    end

endmodule

// File: rtl/di_axil_reg_slave.sv
// AXI-Lite slave with 4 control words, status, version, W1C events and irq mask.
module di_axil_reg_slave
    import di_axil_pkg::*;
#(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 5,
    parameter logic [31:0] C_VERSION          = DEFAULT_VERSION
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [127:0]                    ctrl_o,
    input  logic [31:0]                     status_i,
    input  logic [31:0]                     event_i,
    output logic                            irq_o
);

    logic        rst_meta_q, rst_sync_q;
    logic        active;
    logic [31:0] ctrl_q [4];
    logic [31:0] ctrl_d [4];
    logic [31:0] evt_q, evt_d, evt_clr;
    logic [31:0] mask_q, mask_d;
    logic        irq_q;
    logic        bvalid_q;
    logic [1:0]  bresp_q, wr_resp;
    logic        rvalid_q;
    logic [31:0] rdata_q, rd_word;
    logic [1:0]  rresp_q;
    logic        wr_commit;
    logic [C_S_AXI_ADDR_WIDTH-1:0]   wr_addr;
    logic [C_S_AXI_DATA_WIDTH-1:0]   wr_data;
    logic [C_S_AXI_DATA_WIDTH/8-1:0] wr_strb;
    logic [2:0]  wr_word, ar_word;
    logic        ar_hs;
    logic        unused_bits;

    // Reset asserts asynchronously but READY only rises two edges after release.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= 1'b1;
        end else begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= rst_meta_q;
        end
    end

    assign active = ~rst_sync_q;

    di_axil_wr_capture #(
        .ADDR_W (C_S_AXI_ADDR_WIDTH),
        .DATA_W (C_S_AXI_DATA_WIDTH)
    ) u_wr_capture (
        .clk_i     (S_AXI_ACLK),
        .rst_i     (S_AXI_ARESET),
        .en_i      (active),
        .busy_i    (bvalid_q),
        .awvalid_i (S_AXI_AWVALID),
        .awaddr_i  (S_AXI_AWADDR),
        .awready_o (S_AXI_AWREADY),
        .wvalid_i  (S_AXI_WVALID),
        .wdata_i   (S_AXI_WDATA),
        .wstrb_i   (S_AXI_WSTRB),
        .wready_o  (S_AXI_WREADY),
        .commit_o  (wr_commit),
        .addr_o    (wr_addr),
        .data_o    (wr_data),
        .strb_o    (wr_strb)
    );

    assign wr_word       = wr_addr[4:2];
    assign ar_word       = S_AXI_ARADDR[4:2];
    assign S_AXI_ARREADY = active & ~rvalid_q;
    assign ar_hs         = S_AXI_ARVALID & S_AXI_ARREADY;
    assign unused_bits   = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_ARADDR[1:0], wr_addr[1:0]};

    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            ctrl_d[i] = ctrl_q[i];
        end
        mask_d  = mask_q;
        evt_clr = '0;
        wr_resp = RESP_OKAY;
        if (wr_commit) begin
            case (wr_word)
                WORD_STATUS, WORD_VERSION: wr_resp = RESP_SLVERR;
                WORD_EVENT:                evt_clr = wr_data & strb_to_mask(wr_strb);
                WORD_MASK:                 mask_d  = apply_strb(mask_q, wr_data, wr_strb);
                default:                   ctrl_d[wr_word[1:0]] =
                                               apply_strb(ctrl_q[wr_word[1:0]], wr_data, wr_strb);
            endcase
        end
        // A new event in the clearing cycle must survive the W1C.
        evt_d = (evt_q & ~evt_clr) | event_i;
    end

    always_comb begin
        case (ar_word)
            WORD_STATUS:  rd_word = status_i;
            WORD_VERSION: rd_word = C_VERSION;
            WORD_EVENT:   rd_word = evt_q;
            WORD_MASK:    rd_word = mask_q;
            default:      rd_word = ctrl_q[ar_word[1:0]];
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            for (int unsigned i = 0; i < 4; i++) begin
                ctrl_q[i] <= '0;
            end
            evt_q    <= '0;
            mask_q   <= '0;
            irq_q    <= 1'b0;
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                ctrl_q[i] <= ctrl_d[i];
            end
            evt_q  <= evt_d;
            mask_q <= mask_d;
            irq_q  <= |(evt_q & mask_q);
            if (wr_commit) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_resp;
            end else if (S_AXI_BREADY) begin
                bvalid_q <= 1'b0;
            end
            if (ar_hs) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_word;
                rresp_q  <= RESP_OKAY;
            end else if (S_AXI_RREADY) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    assign S_AXI_BVALID = bvalid_q;
    assign S_AXI_BRESP  = bresp_q;
    assign S_AXI_RVALID = rvalid_q;
    assign S_AXI_RDATA  = rdata_q;
    assign S_AXI_RRESP  = rresp_q;
    assign ctrl_o       = {ctrl_q[3], ctrl_q[2], ctrl_q[1], ctrl_q[0]};
    assign irq_o        = irq_q;

endmodule

// File: tb/tb_di_axil_reg_slave.sv
// Directed self-checking bench for di_axil_reg_slave.
module tb_di_axil_reg_slave;

    logic         clk = 1'b0;
    logic         S_AXI_ARESET = 1'b0;
    logic [4:0]   S_AXI_AWADDR = '0;
    logic [2:0]   S_AXI_AWPROT = '0;
    logic         S_AXI_AWVALID = 1'b0;
    logic         S_AXI_AWREADY;
    logic [31:0]  S_AXI_WDATA = '0;
    logic [3:0]   S_AXI_WSTRB = '0;
    logic         S_AXI_WVALID = 1'b0;
    logic         S_AXI_WREADY;
    logic [1:0]   S_AXI_BRESP;
    logic         S_AXI_BVALID;
    logic         S_AXI_BREADY = 1'b0;
    logic [4:0]   S_AXI_ARADDR = '0;
    logic [2:0]   S_AXI_ARPROT = '0;
    logic         S_AXI_ARVALID = 1'b0;
    logic         S_AXI_ARREADY;
    logic [31:0]  S_AXI_RDATA;
    logic [1:0]   S_AXI_RRESP;
    logic         S_AXI_RVALID;
    logic         S_AXI_RREADY = 1'b0;
    logic [127:0] ctrl_o;
    logic [31:0]  status_i = '0;
    logic [31:0]  event_i = '0;
    logic         irq_o;

    int total = 0;
    int bad   = 0;

    logic [31:0] word_vals [4] = '{32'h0101FFFF, 32'habcd0001, 32'hdead0011, 32'hbeef0011};

    always #5 clk = ~clk;

    di_axil_reg_slave #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (5),
        .C_VERSION          (32'h0001_0000)
    ) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESET  (S_AXI_ARESET),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWPROT  (S_AXI_AWPROT),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARPROT  (S_AXI_ARPROT),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY),
        .ctrl_o        (ctrl_o),
        .status_i      (status_i),
        .event_i       (event_i),
        .irq_o         (irq_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        bit aw_done, w_done, aw_hs, w_hs, got_b;
        aw_done = 0; w_done = 0; got_b = 0; resp = 2'bxx;
        S_AXI_AWADDR = addr; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = data; S_AXI_WSTRB = strb; S_AXI_WVALID = 1'b1;
        for (int i = 0; i < 20 && !(aw_done && w_done); i++) begin
            aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
            w_hs  = S_AXI_WVALID && S_AXI_WREADY;
            tick();
            if (aw_hs) begin aw_done = 1; S_AXI_AWVALID = 1'b0; end
            if (w_hs)  begin w_done = 1;  S_AXI_WVALID = 1'b0; end
        end
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        S_AXI_BREADY = 1'b1;
        for (int i = 0; i < 20 && !got_b; i++) begin
            if (S_AXI_BVALID) begin got_b = 1; resp = S_AXI_BRESP; end
            tick();
        end
        S_AXI_BREADY = 1'b0;
        total++;
        if (!got_b) begin
            bad++;
            $display("FAIL write_timeout addr=%h got=no_bvalid exp=bvalid", addr);
        end
    endtask

    task automatic axi_read(input logic [4:0] addr, output logic [31:0] data,
                            output logic [1:0] resp);
        bit ar_done, ar_hs, got_r;
        ar_done = 0; got_r = 0; data = 'x; resp = 2'bxx;
        S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1;
        for (int i = 0; i < 20 && !ar_done; i++) begin
            ar_hs = S_AXI_ARREADY;
            tick();
            if (ar_hs) ar_done = 1;
        end
        S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY = 1'b1;
        for (int i = 0; i < 20 && !got_r; i++) begin
            if (S_AXI_RVALID) begin got_r = 1; data = S_AXI_RDATA; resp = S_AXI_RRESP; end
            tick();
        end
        S_AXI_RREADY = 1'b0;
        total++;
        if (!got_r) begin
            bad++;
            $display("FAIL read_timeout addr=%h got=no_rvalid exp=rvalid", addr);
        end
    endtask

    task automatic test_reset();
        #2 S_AXI_ARESET = 1'b1;
        repeat (3) tick();
        total++; if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b000) begin
            bad++; $display("FAIL reset_ready got=%b exp=000", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}); end
        total++; if ({S_AXI_BVALID, S_AXI_RVALID, irq_o} !== 3'b000) begin
            bad++; $display("FAIL reset_valid_irq got=%b exp=000", {S_AXI_BVALID, S_AXI_RVALID, irq_o}); end
        total++; if ({S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA} !== 36'h0) begin
            bad++; $display("FAIL reset_resp_rdata got=%h exp=0", {S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA}); end
        total++; if (ctrl_o !== 128'h0) begin
            bad++; $display("FAIL reset_ctrl got=%h exp=0", ctrl_o); end
        S_AXI_ARESET = 1'b0;
        tick();
        total++; if (S_AXI_AWREADY !== 1'b0) begin
            bad++; $display("FAIL release_early_awready got=%b exp=0", S_AXI_AWREADY); end
        tick();
        total++; if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b111) begin
            bad++; $display("FAIL release_ready got=%b exp=111", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}); end
    endtask

    task automatic test_rw_words();
        logic [31:0] rd; logic [1:0] resp;
        for (int i = 0; i < 4; i++) begin
            axi_write(5'(i * 4), word_vals[i], 4'hF, resp);
            total++; if (resp !== 2'b00) begin
                bad++; $display("FAIL rw_bresp word=%0d got=%b exp=00", i, resp); end
            axi_read(5'(i * 4), rd, resp);
            total++; if (rd !== word_vals[i]) begin
                bad++; $display("FAIL rw_rdata word=%0d got=%h exp=%h", i, rd, word_vals[i]); end
            total++; if (resp !== 2'b00) begin
                bad++; $display("FAIL rw_rresp word=%0d got=%b exp=00", i, resp); end
        end
        total++; if (ctrl_o !== 128'hbeef0011_dead0011_abcd0001_0101FFFF) begin
            bad++; $display("FAIL rw_ctrl_o got=%h exp=beef0011dead0011abcd00010101ffff", ctrl_o); end
    endtask

    task automatic test_order();
        logic [31:0] rd; logic [1:0] resp;
        S_AXI_WDATA = 32'h11112222; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        total++; if (S_AXI_WREADY !== 1'b1) begin
            bad++; $display("FAIL order_wready_idle got=%b exp=1", S_AXI_WREADY); end
        tick();
        S_AXI_WVALID = 1'b0;
        for (int i = 0; i < 2; i++) begin
            total++; if (S_AXI_WREADY !== 1'b0) begin
                bad++; $display("FAIL order_wready_pending got=%b exp=0", S_AXI_WREADY); end
            total++; if (S_AXI_BVALID !== 1'b0) begin
                bad++; $display("FAIL order_early_bvalid got=%b exp=0", S_AXI_BVALID); end
            tick();
        end
        S_AXI_AWADDR = 5'h08; S_AXI_AWVALID = 1'b1;
        total++; if (S_AXI_AWREADY !== 1'b1) begin
            bad++; $display("FAIL order_awready got=%b exp=1", S_AXI_AWREADY); end
        tick();
        S_AXI_AWVALID = 1'b0;
        total++; if (S_AXI_BVALID !== 1'b0) begin
            bad++; $display("FAIL order_commit_cycle_bvalid got=%b exp=0", S_AXI_BVALID); end
        tick();
        S_AXI_AWADDR = 5'h0C; S_AXI_AWVALID = 1'b1;
        for (int i = 0; i < 5; i++) begin
            total++; if ({S_AXI_BVALID, S_AXI_BRESP, S_AXI_AWREADY} !== 4'b1000) begin
                bad++; $display("FAIL order_b_hold cyc=%0d got=%b exp=1000", i,
                                {S_AXI_BVALID, S_AXI_BRESP, S_AXI_AWREADY}); end
            tick();
        end
        S_AXI_BREADY = 1'b1;
        tick();
        S_AXI_BREADY = 1'b0;
        total++; if ({S_AXI_BVALID, S_AXI_AWREADY} !== 2'b01) begin
            bad++; $display("FAIL order_after_b got=%b exp=01", {S_AXI_BVALID, S_AXI_AWREADY}); end
        tick();
        S_AXI_AWVALID = 1'b0;
        total++; if ({S_AXI_AWREADY, S_AXI_WREADY} !== 2'b01) begin
            bad++; $display("FAIL order_aw_pending got=%b exp=01", {S_AXI_AWREADY, S_AXI_WREADY}); end
        tick();
        S_AXI_WDATA = 32'h33334444; S_AXI_WVALID = 1'b1;
        tick();
        S_AXI_WVALID = 1'b0;
        total++; if (S_AXI_BVALID !== 1'b0) begin
            bad++; $display("FAIL order2_commit_cycle_bvalid got=%b exp=0", S_AXI_BVALID); end
        tick();
        total++; if ({S_AXI_BVALID, S_AXI_BRESP} !== 3'b100) begin
            bad++; $display("FAIL order2_bvalid got=%b exp=100", {S_AXI_BVALID, S_AXI_BRESP}); end
        S_AXI_BREADY = 1'b1;
        tick();
        S_AXI_BREADY = 1'b0;
        total++; if (S_AXI_BVALID !== 1'b0) begin
            bad++; $display("FAIL order2_bclear got=%b exp=0", S_AXI_BVALID); end
        axi_read(5'h08, rd, resp);
        total++; if (rd !== 32'h11112222) begin
            bad++; $display("FAIL order_word2 got=%h exp=11112222", rd); end
        axi_read(5'h0C, rd, resp);
        total++; if (rd !== 32'h33334444) begin
            bad++; $display("FAIL order_word3 got=%h exp=33334444", rd); end
    endtask

    task automatic test_strobe();
        logic [31:0] rd; logic [1:0] resp;
        axi_write(5'h00, 32'hFFFFFFFF, 4'hF, resp);
        axi_write(5'h00, 32'h12345678, 4'b0101, resp);
        axi_read(5'h00, rd, resp);
        total++; if (rd !== 32'hFF34FF78) begin
            bad++; $display("FAIL strobe_0101 got=%h exp=ff34ff78", rd); end
        axi_write(5'h00, 32'hAAAAAAAA, 4'b0000, resp);
        total++; if (resp !== 2'b00) begin
            bad++; $display("FAIL strobe_zero_resp got=%b exp=00", resp); end
        axi_read(5'h00, rd, resp);
        total++; if (rd !== 32'hFF34FF78) begin
            bad++; $display("FAIL strobe_zero_data got=%h exp=ff34ff78", rd); end
    endtask

    task automatic test_readonly();
        logic [31:0] rd; logic [1:0] resp;
        axi_write(5'h14, 32'h5555AAAA, 4'hF, resp);
        total++; if (resp !== 2'b10) begin
            bad++; $display("FAIL ro_version_bresp got=%b exp=10", resp); end
        axi_read(5'h14, rd, resp);
        total++; if (rd !== 32'h0001_0000) begin
            bad++; $display("FAIL ro_version_read got=%h exp=00010000", rd); end
        axi_write(5'h10, 32'h5555AAAA, 4'hF, resp);
        total++; if (resp !== 2'b10) begin
            bad++; $display("FAIL ro_status_bresp got=%b exp=10", resp); end
        status_i = 32'hCAFE0001;
        axi_read(5'h11, rd, resp);
        total++; if (rd !== 32'hCAFE0001) begin
            bad++; $display("FAIL ro_status_read got=%h exp=cafe0001", rd); end
    endtask

    task automatic test_events();
        logic [31:0] rd; logic [1:0] resp;
        event_i = 32'h8;
        tick();
        event_i = 32'h0;
        axi_read(5'h18, rd, resp);
        total++; if (rd !== 32'h8) begin
            bad++; $display("FAIL evt_latch got=%h exp=00000008", rd); end
        total++; if (irq_o !== 1'b0) begin
            bad++; $display("FAIL evt_irq_masked got=%b exp=0", irq_o); end
        axi_write(5'h1C, 32'h8, 4'hF, resp);
        total++; if (irq_o !== 1'b1) begin
            bad++; $display("FAIL evt_irq_on got=%b exp=1", irq_o); end
        S_AXI_AWADDR = 5'h18; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = 32'h8; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        event_i = 32'h8;
        tick();
        event_i = 32'h0;
        total++; if (S_AXI_BVALID !== 1'b1) begin
            bad++; $display("FAIL evt_w1c_bvalid got=%b exp=1", S_AXI_BVALID); end
        S_AXI_BREADY = 1'b1;
        tick();
        S_AXI_BREADY = 1'b0;
        axi_read(5'h18, rd, resp);
        total++; if (rd !== 32'h8) begin
            bad++; $display("FAIL evt_set_wins got=%h exp=00000008", rd); end
        total++; if (irq_o !== 1'b1) begin
            bad++; $display("FAIL evt_irq_held got=%b exp=1", irq_o); end
        axi_write(5'h18, 32'h8, 4'hF, resp);
        axi_read(5'h18, rd, resp);
        total++; if (rd !== 32'h0) begin
            bad++; $display("FAIL evt_w1c got=%h exp=00000000", rd); end
        total++; if (irq_o !== 1'b0) begin
            bad++; $display("FAIL evt_irq_off got=%b exp=0", irq_o); end
    endtask

    task automatic test_reset_midflight();
        logic [31:0] rd; logic [1:0] resp;
        S_AXI_AWADDR = 5'h04; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = 32'h77778888; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        S_AXI_ARADDR = 5'h04; S_AXI_ARVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
        tick();
        total++; if ({S_AXI_BVALID, S_AXI_RVALID} !== 2'b11) begin
            bad++; $display("FAIL rstmid_pre got=%b exp=11", {S_AXI_BVALID, S_AXI_RVALID}); end
        #1 S_AXI_ARESET = 1'b1;
        #1;
        total++; if ({S_AXI_BVALID, S_AXI_RVALID, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, irq_o} !== 6'b0) begin
            bad++; $display("FAIL rstmid_flags got=%b exp=000000",
                            {S_AXI_BVALID, S_AXI_RVALID, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, irq_o}); end
        total++; if ({ctrl_o, S_AXI_RDATA, S_AXI_BRESP, S_AXI_RRESP} !== 164'h0) begin
            bad++; $display("FAIL rstmid_data got=%h exp=0", {ctrl_o, S_AXI_RDATA, S_AXI_BRESP, S_AXI_RRESP}); end
        tick(); tick();
        S_AXI_ARESET = 1'b0;
        tick(); tick();
        S_AXI_AWADDR = 5'h04; S_AXI_AWVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0;
        S_AXI_ARESET = 1'b1;
        tick();
        S_AXI_ARESET = 1'b0;
        tick(); tick();
        total++; if (S_AXI_AWREADY !== 1'b1) begin
            bad++; $display("FAIL rstmid_aw_dropped got=%b exp=1", S_AXI_AWREADY); end
        axi_write(5'h04, 32'h5A5A1234, 4'hF, resp);
        total++; if (resp !== 2'b00) begin
            bad++; $display("FAIL rstmid_bresp got=%b exp=00", resp); end
        axi_read(5'h04, rd, resp);
        total++; if (rd !== 32'h5A5A1234) begin
            bad++; $display("FAIL rstmid_readback got=%h exp=5a5a1234", rd); end
        total++; if (ctrl_o !== 128'h00000000_00000000_5A5A1234_00000000) begin
            bad++; $display("FAIL rstmid_ctrl_o got=%h exp=000000000000000005a5a123400000000", ctrl_o); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_rw_words();
        test_order();
        test_strobe();
        test_readonly();
        test_events();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
